// File: rtl/strided_read_pkg.sv
// Shared types for the strided read accumulator: FSM encoding and AXI response codes.
package strided_read_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } srd_state_t;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/strided_read_accumulator_lane_reducer.sv
// Sums all unsigned LANE_BITS lanes of a data word into a SUM_BITS result (mod 2^SUM_BITS).
module lane_reducer #(
  parameter int DATA_BITS = 64,
  parameter int LANE_BITS = 16,
  parameter int SUM_BITS  = 32
) (
  input  logic [DATA_BITS-1:0] data_i,
  output logic [SUM_BITS-1:0]  sum_o
);

  localparam int LANES = DATA_BITS / LANE_BITS;

  // Each lane is zero-extended before it joins the sum.
  always_comb begin
    sum_o = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_o = sum_o + SUM_BITS'(data_i[i*LANE_BITS +: LANE_BITS]);
    end
  end

endmodule

// File: rtl/strided_read_accumulator.sv
// Issues AXI reads over base + i*stride, keeps up to MAX_OUTSTANDING in flight,
// and accumulates the lane sum of every OKAY beat returned.
module strided_read_accumulator
  import strided_read_pkg::*;
#(
  parameter int ADDR_BITS       = 17,
  parameter int DATA_BITS       = 64,
  parameter int LANE_BITS       = 16,
  parameter int CNT_BITS        = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int SUM_BITS        = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] cfg_base,
  input  logic [ADDR_BITS-1:0] cfg_stride,
  input  logic [CNT_BITS-1:0]  cfg_count,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [SUM_BITS-1:0]  sum,
  input  logic                 axi_arready,
  output logic                 axi_arvalid,
  output logic [ADDR_BITS-1:0] axi_araddr,
  output logic                 axi_rready,
  input  logic                 axi_rvalid,
  input  logic [DATA_BITS-1:0] axi_rdata,
  input  logic [1:0]           axi_rresp,
  output logic [1:0]           dbg_state
);

  localparam int OUT_BITS = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_BITS-1:0] OUT_MAX = OUT_BITS'(MAX_OUTSTANDING);

  // Handshakes: a transfer happens on a rising clock edge where valid and ready
  // are both high. arvalid/araddr never change while arvalid && !arready;
  // rready is simply high whenever the block is in RUN or DRAIN.

  srd_state_t state_q, state_d;
  logic [ADDR_BITS-1:0] stride_q;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [CNT_BITS-1:0]  count_q;
  logic [CNT_BITS-1:0]  issued_q, issued_d;
  logic [CNT_BITS-1:0]  received_q, received_d;
  logic [OUT_BITS-1:0]  outstanding_q, outstanding_d;
  logic [SUM_BITS-1:0]  sum_q, sum_d;
  logic [SUM_BITS-1:0]  beat_sum;
  logic                 err_q, err_d;
  logic                 busy_q, done_q;
  logic                 start_ok, ar_hs, r_hs, r_expected;

  lane_reducer #(
    .DATA_BITS (DATA_BITS),
    .LANE_BITS (LANE_BITS),
    .SUM_BITS  (SUM_BITS)
  ) u_lane_reducer (
    .data_i (axi_rdata),
    .sum_o  (beat_sum)
  );

  // arvalid depends only on registered state, so once raised it can only drop
  // after the handshake that bumps issued_q.
  assign axi_arvalid = (state_q == ST_RUN) && (issued_q < count_q) && (outstanding_q < OUT_MAX);
  assign axi_araddr  = addr_q;
  assign axi_rready  = (state_q == ST_RUN) || (state_q == ST_DRAIN);

  assign start_ok   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign ar_hs      = axi_arvalid && axi_arready;
  assign r_hs       = axi_rvalid && axi_rready;
  // A beat arriving with nothing in flight is only legitimate if an AR lands the same cycle.
  assign r_expected = r_hs && ((outstanding_q != '0) || ar_hs);

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    issued_d      = issued_q;
    received_d    = received_q;
    outstanding_d = outstanding_q;
    sum_d         = sum_q;
    err_d         = err_q;

    if (ar_hs) begin
      addr_d   = addr_q + stride_q;
      issued_d = issued_q + 1'b1;
    end

    if (ar_hs && !r_expected) begin
      outstanding_d = outstanding_q + 1'b1;
    end else if (!ar_hs && r_expected) begin
      outstanding_d = outstanding_q - 1'b1;
    end

    if (r_expected) begin
      received_d = received_q + 1'b1;
      if (axi_rresp == AXI_RESP_OKAY) begin
        sum_d = sum_q + beat_sum;
      end else begin
        err_d = 1'b1;
      end
    end else if (r_hs) begin
      err_d = 1'b1;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          state_d    = (cfg_count == '0) ? ST_DONE : ST_RUN;
          addr_d     = cfg_base;
          issued_d   = '0;
          received_d = '0;
          sum_d      = '0;
          err_d      = 1'b0;
        end
      end
      ST_RUN: begin
        if (issued_d == count_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (outstanding_d == '0) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      stride_q      <= '0;
      addr_q        <= '0;
      count_q       <= '0;
      issued_q      <= '0;
      received_q    <= '0;
      outstanding_q <= '0;
      sum_q         <= '0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      issued_q      <= issued_d;
      received_q    <= received_d;
      outstanding_q <= outstanding_d;
      sum_q         <= sum_d;
      err_q         <= err_d;
      busy_q        <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
      done_q        <= (state_d == ST_DONE);
      if (start_ok) begin
        stride_q <= cfg_stride;
        count_q  <= cfg_count;
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign sum       = sum_q;
  assign dbg_state = state_q;

  a_outstanding_max: assert property (@(posedge clock) disable iff (reset)
    outstanding_q <= OUT_MAX);
  a_ar_stable: assert property (@(posedge clock) disable iff (reset)
    (axi_arvalid && !axi_arready) |=> (axi_arvalid && $stable(axi_araddr)));
  a_recv_le_issued: assert property (@(posedge clock) disable iff (reset)
    received_q <= issued_q);

endmodule

// File: tb/tb_strided_read_accumulator.sv
// Bench for strided_read_accumulator: random AXI read slave, reference model of
// addresses and lane sums, and a monitor that checks AR traffic and completions.
module tb_strided_read_accumulator;

  localparam int AW = 17;
  localparam int DW = 64;
  localparam int CW = 16;
  localparam int SW = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] cfg_base = '0;
  logic [AW-1:0] cfg_stride = '0;
  logic [CW-1:0] cfg_count = '0;
  logic          busy, done, err;
  logic [SW-1:0] sum;
  logic          arready = 1'b0;
  logic          arvalid;
  logic [AW-1:0] araddr;
  logic          rready;
  logic          rvalid = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic [1:0]    rresp = 2'b00;
  logic [1:0]    dbg_state;

  strided_read_accumulator dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .cfg_base    (cfg_base),
    .cfg_stride  (cfg_stride),
    .cfg_count   (cfg_count),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .sum         (sum),
    .axi_arready (arready),
    .axi_arvalid (arvalid),
    .axi_araddr  (araddr),
    .axi_rready  (rready),
    .axi_rvalid  (rvalid),
    .axi_rdata   (rdata),
    .axi_rresp   (rresp),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;

  logic [AW-1:0] exp_addr_q[$];
  logic [SW-1:0] exp_sum_q[$];
  logic          exp_err_q[$];
  logic [DW-1:0] beat_data_q[$];
  logic [1:0]    beat_resp_q[$];
  int            pend_due[$];

  int ar_prob     = 100;
  int r_prob      = 100;
  int r_delay_max = 1;
  int ar_budget   = -1;
  int ar_hs_cnt   = 0;
  bit r_block     = 1'b0;
  bit ar_block    = 1'b0;
  bit r_took      = 1'b0;

  bit            prev_start = 1'b0;
  bit            prev_done  = 1'b0;
  bit            prev_wait  = 1'b0;
  logic [AW-1:0] prev_addr  = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_arvalid"}, 64'(arvalid), 64'd0);
    chk({tag, "_araddr"},  64'(araddr),  64'd0);
    chk({tag, "_rready"},  64'(rready),  64'd0);
    chk({tag, "_busy"},    64'(busy),    64'd0);
    chk({tag, "_done"},    64'(done),    64'd0);
    chk({tag, "_err"},     64'(err),     64'd0);
    chk({tag, "_sum"},     64'(sum),     64'd0);
    chk({tag, "_state"},   64'(dbg_state), 64'd0);
  endtask

  task automatic flush_model();
    exp_addr_q.delete();
    exp_sum_q.delete();
    exp_err_q.delete();
    beat_data_q.delete();
    beat_resp_q.delete();
    pend_due.delete();
    ar_budget = -1;
    r_block   = 1'b0;
    ar_block  = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    flush_model();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  // ---------------- AXI read slave ----------------
  // Inputs change at negedge; handshakes are sampled at negedge+1, which sees
  // exactly what the DUT will see at the following posedge.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        r_took  = 1'b0;
        rvalid  = 1'b0;
        arready = 1'b0;
      end else begin
        if (r_took) begin
          r_took = 1'b0;
          rvalid = 1'b0;
          if (pend_due.size() > 0)    void'(pend_due.pop_front());
          if (beat_data_q.size() > 0) void'(beat_data_q.pop_front());
          if (beat_resp_q.size() > 0) void'(beat_resp_q.pop_front());
        end
        arready = !ar_block && (ar_budget != 0) && ($urandom_range(1, 100) <= ar_prob);
        if (!rvalid && !r_block && pend_due.size() > 0 && beat_data_q.size() > 0) begin
          if (pend_due[0] <= cyc && $urandom_range(1, 100) <= r_prob) begin
            rvalid = 1'b1;
            rdata  = beat_data_q[0];
            rresp  = beat_resp_q[0];
          end
        end
        #1;
        if (arvalid && arready) begin
          pend_due.push_back(cyc + $urandom_range(1, r_delay_max));
          ar_hs_cnt++;
          if (ar_budget > 0) ar_budget--;
        end
        if (rvalid && rready) r_took = 1'b1;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (reset) begin
        prev_start = 1'b0;
        prev_done  = 1'b0;
        prev_wait  = 1'b0;
      end else begin
        if (prev_wait) begin
          chk("ar_hold_valid", 64'(arvalid), 64'd1);
          chk("ar_hold_addr", 64'(araddr), 64'(prev_addr));
        end
        if (arvalid && arready) begin
          if (exp_addr_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL ar_unexpected actual=%0h required=none", araddr);
          end else begin
            chk("araddr", 64'(araddr), 64'(exp_addr_q.pop_front()));
          end
        end
        if (done && (!prev_done || prev_start)) begin
          if (exp_sum_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL done_unexpected actual=done required=no_done");
          end else begin
            chk("sum", 64'(sum), 64'(exp_sum_q.pop_front()));
            chk("err", 64'(err), 64'(exp_err_q.pop_front()));
            chk("busy_at_done", 64'(busy), 64'd0);
            chk("all_addr_issued", 64'(exp_addr_q.size()), 64'd0);
          end
        end
        prev_wait = arvalid && !arready;
        prev_addr = araddr;
        prev_done = done;
        prev_start = start;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue_cmd(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                           input int count, input int bad_idx, input bit ones);
    logic [SW-1:0] s;
    logic          e;
    logic [DW-1:0] d;
    s = '0;
    e = 1'b0;
    for (int i = 0; i < count; i++) begin
      d = ones ? 64'h0001_0001_0001_0001 : {$urandom, $urandom};
      beat_data_q.push_back(d);
      if (i == bad_idx) begin
        beat_resp_q.push_back(2'b10);
        e = 1'b1;
      end else begin
        beat_resp_q.push_back(2'b00);
        for (int l = 0; l < 4; l++) s = s + SW'((d >> (16 * l)) & 64'hFFFF);
      end
      exp_addr_q.push_back(AW'(int'(base) + i * int'(stride)));
    end
    exp_sum_q.push_back(s);
    exp_err_q.push_back(e);
    @(negedge clock);
    cfg_base   = base;
    cfg_stride = stride;
    cfg_count  = CW'(count);
    start      = 1'b1;
    @(negedge clock);
    start      = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!(done && !busy) && n < 3000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 3000) begin
      total++;
      bad++;
      $display("FAIL %s_timeout actual=busy required=done", name);
      apply_reset();
    end
    repeat (3) @(negedge clock);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clock);
    #3;
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clock);

    // Unit-stride style run with known data: four beats of four ones each.
    issue_cmd(17'h00100, 17'd8, 4, -1, 1'b1);
    wait_done("basic");

    // Read responses held off: issue must stall at four in flight.
    r_block   = 1'b1;
    ar_hs_cnt = 0;
    issue_cmd(17'h00200, 17'd4, 10, -1, 1'b0);
    repeat (20) @(negedge clock);
    #3;
    chk("maxout_ar_count", 64'(ar_hs_cnt), 64'd4);
    chk("maxout_arvalid", 64'(arvalid), 64'd0);
    chk("maxout_busy", 64'(busy), 64'd1);
    r_block = 1'b0;
    wait_done("maxout");

    // arready stalled mid-burst.
    issue_cmd(17'h00400, 17'd4, 8, -1, 1'b0);
    repeat (2) @(negedge clock);
    ar_block = 1'b1;
    repeat (2) @(negedge clock);
    #3;
    chk("stall_arvalid", 64'(arvalid), 64'd1);
    repeat (4) @(negedge clock);
    ar_block = 1'b0;
    wait_done("stall");

    // Address wrap at the top of the address space.
    issue_cmd(17'h1FFF8, 17'd16, 2, -1, 1'b0);
    wait_done("wrap");

    // Zero-length command completes immediately with no AR.
    issue_cmd(17'h00040, 17'd4, 0, -1, 1'b0);
    #3;
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_arvalid", 64'(arvalid), 64'd0);
    wait_done("zero");

    // One SLVERR beat: flagged and excluded from the sum.
    issue_cmd(17'h00300, 17'd8, 5, 2, 1'b0);
    wait_done("slverr");

    // Reset with three reads in flight.
    r_block   = 1'b1;
    ar_budget = 3;
    ar_hs_cnt = 0;
    issue_cmd(17'h00500, 17'd8, 10, -1, 1'b0);
    repeat (15) @(negedge clock);
    #3;
    chk("midrst_ar_count", 64'(ar_hs_cnt), 64'd3);
    chk("midrst_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    flush_model();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    issue_cmd(17'h00600, 17'd12, 6, -1, 1'b0);
    wait_done("after_reset");

    // Randomized commands with random slave timing.
    for (int t = 0; t < 14; t++) begin
      int cnt;
      int bidx;
      ar_prob     = $urandom_range(30, 100);
      r_prob      = $urandom_range(30, 100);
      r_delay_max = $urandom_range(1, 5);
      cnt         = $urandom_range(1, 12);
      bidx        = ($urandom_range(0, 3) == 0) ? $urandom_range(0, cnt - 1) : -1;
      issue_cmd(AW'($urandom), AW'(($urandom_range(0, 1) == 0) ? $urandom_range(1, 64) : $urandom),
                cnt, bidx, 1'b0);
      wait_done("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
